// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB writeback path.
// Default widths, execution-unit indices and the default-width result entry.
package cdb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int TAG_W_DEF   = 6;
    localparam int DATA_W_DEF  = 32;
    localparam int ID_W_DEF    = 6;

    localparam int EXU_JMP = 0;
    localparam int EXU_LSU = 1;
    localparam int EXU_MDU = 2;
    localparam int EXU_ALU = 3;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] wdata;
        logic [ID_W_DEF-1:0]   inst_id;
    } cdb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search from ptr, ptr advances past each winner.
// Works for any NUM_REQ, including non-powers of two.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_ptr,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic             found;

    // NOTE: every signal assigned in always_comb gets a default up front so no path leaves it unassigned (no latch).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

    assign ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst || clr_ptr) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/cdb_rr_sched.sv
// Round-robin CDB writeback scheduler: one holding slot per execution unit,
// one registered broadcast per cycle, flush kills every buffered result.
module cdb_rr_sched
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*TAG_W-1:0]  tag_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    input  logic [NUM_REQ*ID_W-1:0]   inst_id_i,
    output logic [NUM_REQ-1:0]      rdy_o,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic                    cdb_wr,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_wdata,
    output logic [ID_W-1:0]         cdb_inst_id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] wdata;
        logic [ID_W-1:0]   inst_id;
    } entry_t;

    entry_t             in_e   [NUM_REQ];
    entry_t             slot_q [NUM_REQ];
    logic [NUM_REQ-1:0] slot_v;
    logic [NUM_REQ-1:0] accept;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any_gnt;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_e[i] = '{tag:     tag_i[i*TAG_W +: TAG_W],
                        wdata:   wdata_i[i*DATA_W +: DATA_W],
                        inst_id: inst_id_i[i*ID_W +: ID_W]};
        end
    end

    // Flush masks the request vector, so grant_o and the pointer advance are both suppressed.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .clr_ptr (1'b0),
        .req     (slot_v & {NUM_REQ{~flush}}),
        .adv     (any_gnt),
        .gnt     (grant_o),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt = |grant_o;
    assign rdy_o   = {NUM_REQ{~flush}} & (~slot_v | grant_o);
    assign accept  = req_i & rdy_o;

    // NOTE: slot payloads are not reset; slot_v alone decides whether the contents mean anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) slot_q[i] <= in_e[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slot_v      <= '0;
            cdb_wr      <= 1'b0;
            cdb_tag     <= '0;
            cdb_wdata   <= '0;
            cdb_inst_id <= '0;
        end else begin
            // A refill in the same edge as the drain keeps the slot full.
            slot_v <= accept | (slot_v & ~grant_o);
            cdb_wr <= any_gnt;
            if (any_gnt) begin
                cdb_tag     <= slot_q[gnt_idx].tag;
                cdb_wdata   <= slot_q[gnt_idx].wdata;
                cdb_inst_id <= slot_q[gnt_idx].inst_id;
            end else begin
                cdb_tag     <= '0;
                cdb_wdata   <= '0;
                cdb_inst_id <= '0;
            end
        end
    end

endmodule
